// File: rtl/enet_clk_pkg.sv
// Shared types and helpers for the Ethernet clock-enable generator.
// Holds the lock FSM encoding, the channel limit and the divisor lookup.
package enet_clk_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    QUALIFY  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int MAX_CH    = 8;
  localparam int MAX_DIV_W = 32;

  // Pull divisor k out of a packed table of dw-bit fields
  // and clamp 0 to 1, so a zero entry means "every cycle".
  function automatic logic [MAX_DIV_W-1:0] div_of(
    input logic [MAX_CH*MAX_DIV_W-1:0] divs,
    input int                          k,
    input int                          dw
  );
    logic [MAX_DIV_W-1:0] d;
    d = '0;
    for (int b = 0; b < MAX_DIV_W; b++) begin
      if (b < dw) d[b] = divs[k*dw+b];
    end
    if (d == '0) d = MAX_DIV_W'(1);
    return d;
  endfunction

endpackage

// File: rtl/enet_clk_div.sv
// One channel of the enable generator: a modulo-div counter.
// Ports: refclk, rst, run (locked next cycle), div (>=1), strobe.
module enet_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last;
  logic             run_q;

  // strobe is the look-ahead value: the parent registers it,
  // so the registered enable lines up with cnt_q == div-1.
  // The first locked cycle always has cnt 0, which keeps
  // every channel phase-aligned.
  always_comb begin
    last  = div - DIV_W'(1);
    cnt_d = '0;
    if (run && run_q && (cnt_q != last)) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    strobe = run && (cnt_d == last);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run;
    end
  end

endmodule

// File: rtl/enet_clk_en_gen.sv
// Lock-qualified, phase-aligned clock-enable generator with a
// handshaked, glitch-free speed select for the MAC.
// Ports: refclk/rst, pll_locked, sel/sel_req -> sel_ack/sel_busy,
// cur_sel, clk_en[NUM_CH], sel_clk_en, locked.
// Option ENET_CLK_EN_STATUS_EN adds status_clr and lock_loss_cnt.
module enet_clk_en_gen
  import enet_clk_pkg::*;
#(
  parameter int                       NUM_CH      = 3,
  parameter int                       DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]  DIVS        = {8'd50, 8'd5, 8'd1},
  parameter int                       LOCK_STABLE = 1024,
  parameter int                       RESET_SEL   = 0,
  localparam int                      SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_req,
  output logic              sel_ack,
  output logic              sel_busy,
  output logic [SEL_W-1:0]  cur_sel,
  output logic [NUM_CH-1:0] clk_en,
  output logic              sel_clk_en,
  output logic              locked
`ifdef ENET_CLK_EN_STATUS_EN
  ,
  input  logic              status_clr,
  output logic [15:0]       lock_loss_cnt
`endif
);

  localparam int QW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(LOCK_STABLE - 1);
  localparam logic [MAX_CH*MAX_DIV_W-1:0] DIVS_X =
    (MAX_CH*MAX_DIV_W)'(DIVS);

  // ---------------- lock synchroniser ----------------
  logic lk_meta_q;
  logic lk_s_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  // ---------------- lock FSM ----------------
  lock_state_t   state_q;
  lock_state_t   state_d;
  logic [QW-1:0] qcnt_q;
  logic [QW-1:0] qcnt_d;
  logic          locked_q;
  logic          locked_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      UNLOCKED: begin
        qcnt_d = '0;
        if (lk_s_q) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!lk_s_q) begin
          state_d = UNLOCKED;
          qcnt_d  = '0;
        end else if (qcnt_q == Q_LAST) begin
          state_d = LOCKED;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      LOCKED: begin
        if (!lk_s_q) state_d = UNLOCKED;
      end
      default: begin
        state_d = UNLOCKED;
        qcnt_d  = '0;
      end
    endcase
  end

  // locked is taken from the next state so it tracks
  // state_q == LOCKED exactly while coming from a flop.
  always_comb begin
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end

  // ---------------- dividers ----------------
  logic [NUM_CH-1:0] strobe_nxt;
  logic [NUM_CH-1:0] clk_en_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_K =
      DIV_W'(div_of(DIVS_X, k, DIV_W));

    enet_clk_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .refclk (refclk),
      .rst    (rst),
      .run    (locked_d),
      .div    (DIV_K),
      .strobe (strobe_nxt[k])
    );
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) clk_en_q <= '0;
    else     clk_en_q <= strobe_nxt;
  end

  // ---------------- selection ----------------
  logic [SEL_W-1:0] cur_sel_q;
  logic [SEL_W-1:0] cur_sel_d;
  logic [SEL_W-1:0] pend_q;
  logic [SEL_W-1:0] pend_d;
  logic             busy_q;
  logic             busy_d;
  logic             ack_q;
  logic             ack_d;
  logic             pend_hit;
  logic             hold;
  logic             sel_ok;

  always_comb begin
    cur_sel_d = cur_sel_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    // Switches wait for a strobe only if lock holds across the edge.
    hold      = locked_q && locked_d;
    sel_ok    = (int'(sel) < NUM_CH);
    // Completion is decided one cycle early so cur_sel and
    // sel_ack land on the same cycle as the new channel's strobe.
    pend_hit  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pend_q == SEL_W'(k)) pend_hit = strobe_nxt[k];
    end
    if (busy_q) begin
      if (!locked_d || pend_hit) begin
        cur_sel_d = pend_q;
        busy_d    = 1'b0;
        ack_d     = 1'b1;
      end
    end else if (sel_req && sel_ok) begin
      if (sel == cur_sel_q) begin
        ack_d = 1'b1;
      end else if (!hold) begin
        cur_sel_d = sel;
        ack_d     = 1'b1;
      end else begin
        pend_d = sel;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cur_sel_q <= SEL_W'(RESET_SEL);
      pend_q    <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cur_sel_q <= cur_sel_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  logic sel_en;

  always_comb begin
    sel_en = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_sel_q == SEL_W'(k)) sel_en = clk_en_q[k];
    end
  end

  assign sel_clk_en = sel_en && !busy_q;
  assign sel_ack    = ack_q;
  assign sel_busy   = busy_q;
  assign cur_sel    = cur_sel_q;
  assign clk_en     = clk_en_q;
  assign locked     = locked_q;

`ifdef ENET_CLK_EN_STATUS_EN
  // ---------------- lock-loss status ----------------
  logic [15:0] llc_q;
  logic [15:0] llc_d;

  always_comb begin
    llc_d = llc_q;
    if (status_clr) begin
      llc_d = '0;
    end else if ((state_q == LOCKED) && (state_d == UNLOCKED)
                 && (llc_q != 16'hFFFF)) begin
      llc_d = llc_q + 16'd1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) llc_q <= '0;
    else     llc_q <= llc_d;
  end

  assign lock_loss_cnt = llc_q;
`endif

endmodule
